// File: rtl/rw_strobe_gen_pkg.sv
// Shared types, defaults and helpers for the rw_strobe_gen sequencer.
package rw_strobe_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_WR,
        S_RD,
        S_NEXT,
        S_DONE
    } rwg_state_e;

    localparam int         DEF_WINDOW    = 10;
    localparam int         DEF_START_DLY = 2;
    localparam logic [7:0] DEF_PATTERN   = 8'hA5;

    // Write data for an address; callers truncate to their data width.
    function automatic logic [31:0] exp_data(input logic [31:0] addr,
                                             input logic [31:0] pattern = 32'(DEF_PATTERN));
        return pattern ^ addr;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rw_window_timer.sv
// Ack-window down-counter shared by the write and read strobes.
// expired_o is high on the WINDOW-th edge after load_i with no clear_i in between.
module rw_window_timer
    import rw_strobe_gen_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        // NOTE: defaults first so every path assigns cnt_d/run_d and no latch is inferred.
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = CW'(WINDOW - 1);
            run_d = 1'b1;
        end else if (clear_i) begin
            run_d = 1'b0;
        end else if (run_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expired_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/rw_strobe_gen.sv
// rw_strobe_gen: start-triggered write-then-read sequencer with ack windows and hit/err counters.
// Define RW_STROBE_GEN_ASSERT_EN to compile in the protocol assertions.
module rw_strobe_gen
    import rw_strobe_gen_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                NUM_TXN   = 4,
    parameter int                START_DLY = DEF_START_DLY,
    parameter int                WINDOW    = DEF_WINDOW,
    parameter logic [DATA_W-1:0] PATTERN   = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              wr_ack,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        hitwr,
    output logic [7:0]        hitrd
);

    localparam int                GW         = (START_DLY > 1) ? $clog2(START_DLY) : 1;
    localparam logic [GW-1:0]     GUARD_INIT = GW'((START_DLY > 0) ? START_DLY - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TXN - 1);

    rwg_state_e        state_q;
    logic [GW-1:0]     guard_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, rd_q, busy_q, done_q, err_q;
    logic [7:0]        hitwr_q, hitrd_q;
    logic              tmr_load, tmr_clear, tmr_expired;

    // Address/data for the next write strobe: 0 at run start, +1 out of NEXT.
    assign addr_d  = (state_q == S_NEXT) ? addr_q + ADDR_W'(1) : '0;
    assign wdata_d = DATA_W'(exp_data(32'(addr_d), 32'(PATTERN)));

    always_comb begin
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        unique case (state_q)
            S_IDLE:  tmr_load  = start && (START_DLY == 0);
            S_GUARD: tmr_load  = (guard_q == '0);
            S_WR: begin
                tmr_load  = wr_ack;
                tmr_clear = tmr_expired;
            end
            S_RD:    tmr_clear = rd_ack || tmr_expired;
            S_NEXT:  tmr_load  = (addr_q != LAST_ADDR);
            default: tmr_clear = 1'b1;
        endcase
    end

    rw_window_timer #(.WINDOW(WINDOW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .clear_i  (tmr_clear),
        .expired_o(tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            guard_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hitwr_q <= '0;
            hitrd_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    busy_q  <= 1'b1;
                    err_q   <= 1'b0;
                    hitwr_q <= '0;
                    hitrd_q <= '0;
                    addr_q  <= addr_d;
                    wdata_q <= wdata_d;
                    guard_q <= GUARD_INIT;
                    if (START_DLY == 0) begin
                        wr_q    <= 1'b1;
                        state_q <= S_WR;
                    end else begin
                        state_q <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (guard_q == '0) begin
                        wr_q    <= 1'b1;
                        state_q <= S_WR;
                    end else begin
                        guard_q <= guard_q - GW'(1);
                    end
                end
                S_WR: begin
                    // Ack wins over a timeout on the same edge.
                    if (wr_ack) begin
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b1;
                        hitwr_q <= sat_inc(hitwr_q);
                        state_q <= S_RD;
                    end else if (tmr_expired) begin
                        wr_q    <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_RD: begin
                    if (rd_ack) begin
                        rd_q    <= 1'b0;
                        hitrd_q <= sat_inc(hitrd_q);
                        if (rd_data != wdata_q) err_q <= 1'b1;
                        state_q <= S_NEXT;
                    end else if (tmr_expired) begin
                        rd_q    <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_NEXT: begin
                    if (addr_q == LAST_ADDR) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        wr_q    <= 1'b1;
                        state_q <= S_WR;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr    = wr_q;
    assign rd    = rd_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign hitwr = hitwr_q;
    assign hitrd = hitrd_q;

`ifdef RW_STROBE_GEN_ASSERT_EN
    a_excl: assert property (@(posedge clk) disable iff (rst) !(wr && rd));

    if (START_DLY > 0) begin : g_guard_chk
        a_guard: assert property (@(posedge clk) disable iff (rst)
            (state_q == S_IDLE && start) |=> (!wr && !rd) [*START_DLY]);
    end

    a_wr_win: assert property (@(posedge clk) disable iff (rst)
        wr |-> ##[0:WINDOW-1] (wr_ack || err));
    a_rd_win: assert property (@(posedge clk) disable iff (rst)
        rd |-> ##[0:WINDOW-1] (rd_ack || err));
    a_done:   assert property (@(posedge clk) disable iff (rst) done |=> !busy);
    a_addr:   assert property (@(posedge clk) disable iff (rst)
        (wr || rd) ##1 (wr || rd) |-> $stable(addr));
`else
    // Synthesis build: no protocol checkers.
`endif

endmodule
